// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word and branch-resolve-queue entry types
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    logic     hit;
    lc3b_word pred;
  } lc3b_brq_entry;

  localparam int BRQ_DEPTH = 4;

endpackage

// File: rtl/brq_array.sv
// rtl/brq_array.sv - entry storage, synchronous write, asynchronous read, no data reset
module brq_array
  import lc3b_types::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  lc3b_brq_entry wdata,
  input  logic [AW-1:0] raddr,
  output lc3b_brq_entry rdata
);

  lc3b_brq_entry mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-flight prediction FIFO that checks outcomes and drives flush/BTB update
module branch_resolve_queue
  import lc3b_types::*;
#(
  parameter int DEPTH = BRQ_DEPTH
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  lc3b_word push_pc,
  input  logic     push_hit,
  input  lc3b_word push_pred,
  input  logic     resolve,
  input  logic     resolve_is_branch,
  input  logic     resolve_taken,
  input  lc3b_word resolve_target,
  output logic     full,
  output logic     empty,
  output logic     mispredict,
  output lc3b_word redirect_pc,
  output logic     btb_taken,
  output lc3b_word btb_write_pc,
  output lc3b_word btb_write_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  lc3b_brq_entry head, wr_entry;
  logic          do_resolve, do_push, taken_br, target_wrong;
  logic          mispredict_next, btb_taken_next;
  lc3b_word      redirect_next;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  assign wr_entry = '{pc: push_pc, hit: push_hit, pred: push_pred};

  brq_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign do_resolve      = resolve & ~empty;
  assign taken_br        = resolve_is_branch & resolve_taken;
  assign target_wrong    = ~head.hit | (head.pred != resolve_target);
  assign btb_taken_next  = do_resolve & taken_br & target_wrong;
  assign mispredict_next = do_resolve & ((taken_br & target_wrong) |
                                         (resolve_is_branch & ~resolve_taken & head.hit) |
                                         (~resolve_is_branch & head.hit));
  assign redirect_next   = taken_br ? resolve_target : head.pc + 16'd2;

  // A push into a full queue is legal only when the head leaves at the same edge;
  // a flush wins over any push because the pushed instruction is on the wrong path.
  assign do_push = push & (~full | do_resolve) & ~mispredict_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (mispredict_next) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push)    wr_ptr <= wr_ptr + AW'(1);
      if (do_resolve) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_resolve);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict     <= 1'b0;
      btb_taken      <= 1'b0;
      redirect_pc    <= '0;
      btb_write_pc   <= '0;
      btb_write_data <= '0;
    end else begin
      mispredict <= mispredict_next;
      btb_taken  <= btb_taken_next;
      if (do_resolve) begin
        redirect_pc    <= redirect_next;
        btb_write_pc   <= head.pc;
        btb_write_data <= resolve_target;
      end
    end
  end

endmodule
